// File: rtl/mem_check_pkg.sv
// Shared types, constants and the data-pattern helper for the memory check initiator.
package mem_check_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_REQ = 3'd1,
    S_WR_GAP = 3'd2,
    S_RD_REQ = 3'd3,
    S_RD_GAP = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  localparam logic [3:0] WSTRB_ALL  = 4'b1111;
  localparam logic [3:0] WSTRB_NONE = 4'b0000;

  function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [31:0] index);
    return seed + index;
  endfunction

endpackage

// File: rtl/mem_check_initiator.sv
// Write-then-read memory test engine on a valid/ready bus with per-request timeout.
// Handshake: a request is presented with mem_valid and held stable until a rising edge
// sees mem_valid && mem_ready; mem_ready with mem_valid low carries no meaning.
module mem_check_initiator
  import mem_check_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic [31:0]      seed,
  output logic             mem_valid,
  output logic             mem_instr,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] error_count,
  output logic [31:0]      first_err_addr,
  output logic [2:0]       dbg_state
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      seed_q, seed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [31:0]      first_q, first_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;

  logic [31:0] cur_addr;
  logic [31:0] cur_pat;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    seed_d    = seed_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    err_d     = err_q;
    first_d   = first_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = WSTRB_NONE;
    cur_addr  = base_q + (32'(idx_q) << 2);
    cur_pat   = pattern(seed_q, 32'(idx_q));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = base_addr & ~32'h3;
          seed_d    = seed;
          cnt_d     = word_count;
          idx_d     = '0;
          wait_d    = '0;
          err_d     = '0;
          first_d   = 32'h0;
          timeout_d = 1'b0;
          state_d   = (word_count == '0) ? S_FINISH : S_WR_REQ;
        end
      end
      S_WR_REQ, S_RD_REQ: begin
        mem_valid = 1'b1;
        mem_addr  = cur_addr;
        if (state_q == S_WR_REQ) begin
          mem_wdata = cur_pat;
          mem_wstrb = WSTRB_ALL;
        end
        if (mem_ready) begin
          idx_d   = idx_q + CNT_W'(1);
          wait_d  = '0;
          state_d = (state_q == S_WR_REQ) ? S_WR_GAP : S_RD_GAP;
          if (state_q == S_RD_REQ && mem_rdata != cur_pat) begin
            // First mismatch is recognisable because the count only ever grows.
            if (err_q == '0) first_d = cur_addr;
            if (err_q != '1) err_d = err_q + CNT_W'(1);
          end
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WR_GAP: begin
        if (idx_q == cnt_q) begin
          idx_d   = '0;
          state_d = S_RD_REQ;
        end else begin
          state_d = S_WR_REQ;
        end
      end
      S_RD_GAP: state_d = (idx_q == cnt_q) ? S_FINISH : S_RD_REQ;
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      base_q    <= 32'h0;
      seed_q    <= 32'h0;
      cnt_q     <= '0;
      idx_q     <= '0;
      wait_q    <= '0;
      err_q     <= '0;
      first_q   <= 32'h0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      seed_q    <= seed_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      first_q   <= first_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  assign mem_instr      = 1'b0;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign error_count    = err_q;
  assign first_err_addr = first_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_check_initiator.sv
// Directed bench for mem_check_initiator: write/read runs, corruption, timeout, reset, wrap.
module tb_mem_check_initiator;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;

  logic             clk;
  logic             resetn;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic [31:0]      seed;
  logic             mem_valid;
  logic             mem_instr;
  logic             mem_ready;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wstrb;
  logic [31:0]      mem_rdata;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] error_count;
  logic [31:0]      first_err_addr;
  logic [2:0]       dbg_state;

  int checks;
  int failures;

  // responder and monitor state
  logic        resp_en;
  logic        corrupt_en;
  logic [31:0] tb_mem [16];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_rd_q[$];
  int          valid_cycles;
  int          gap_viol;
  logic        last_cmp;
  int          cyc;

  mem_check_initiator #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .mem_valid      (mem_valid),
    .mem_instr      (mem_instr),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .error_count    (error_count),
    .first_err_addr (first_err_addr),
    .dbg_state      (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ready = resp_en & mem_valid;
  assign mem_rdata = tb_mem[mem_addr[5:2]] ^
                     ((corrupt_en && mem_addr == 32'h108) ? 32'h1 : 32'h0);

  always @(posedge clk) begin
    if (resetn && mem_valid && mem_ready) begin
      if (mem_wstrb == 4'hF) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
        tb_mem[mem_addr[5:2]] = mem_wdata;
      end else begin
        rd_addr_q.push_back(mem_addr);
      end
    end
    if (mem_valid) valid_cycles++;
    if (last_cmp && mem_valid) gap_viol++;
    last_cmp = resetn && mem_valid && mem_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a run and counts cycles until done (0 if the budget expires).
  // With poke set, a second start with other parameters is pulsed mid-run.
  task automatic run(input logic [31:0] b, input logic [CNT_W-1:0] n, input logic [31:0] s,
                     input int budget, input bit poke, output int cycles);
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    valid_cycles = 0;
    gap_viol     = 0;
    base_addr    = b;
    word_count   = n;
    seed         = s;
    start        = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      if (poke && i == 3) begin
        start      = 1'b1;
        base_addr  = 32'h200;
        word_count = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        cycles = i;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_traffic(input string tag);
    check({tag, "_wr_n"}, 32'(wr_addr_q.size()), 32'(exp_q.size() / 2));
    for (int i = 0; i < wr_addr_q.size() && 2 * i + 1 < exp_q.size(); i++) begin
      check($sformatf("%s_wr_addr%0d", tag, i), wr_addr_q[i], exp_q[2*i]);
      check($sformatf("%s_wr_data%0d", tag, i), wr_data_q[i], exp_q[2*i+1]);
    end
    check({tag, "_rd_n"}, 32'(rd_addr_q.size()), 32'(exp_rd_q.size()));
    for (int i = 0; i < rd_addr_q.size() && i < exp_rd_q.size(); i++)
      check($sformatf("%s_rd_addr%0d", tag, i), rd_addr_q[i], exp_rd_q[i]);
    check({tag, "_gap"}, 32'(gap_viol), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(mem_valid), 32'd0);
    check({tag, "_instr"}, 32'(mem_instr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
    check({tag, "_err"}, 32'(error_count), 32'd0);
    check({tag, "_first"}, first_err_addr, 32'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    resetn     = 1'b0;
    start      = 1'b0;
    base_addr  = 32'h0;
    word_count = '0;
    seed       = 32'h0;
    resp_en    = 1'b1;
    corrupt_en = 1'b0;
    last_cmp   = 1'b0;
    for (int i = 0; i < 16; i++) tb_mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_req", 32'(valid_cycles), 32'd0);

    // basic run, low address bits supplied non-zero on purpose
    exp_q    = '{32'h100, 32'h10, 32'h104, 32'h11, 32'h108, 32'h12, 32'h10C, 32'h13};
    exp_rd_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    run(32'h103, 16'd4, 32'h10, 100, 1'b0, cyc);
    check("basic_done_cyc", 32'(cyc), 32'd18);
    check("basic_busy_at_done", 32'(busy), 32'd0);
    check("basic_err", 32'(error_count), 32'd0);
    check("basic_timeout", 32'(timeout), 32'd0);
    check_traffic("basic");
    @(negedge clk);
    check("basic_done_pulse", 32'(done), 32'd0);

    // read at 0x108 corrupted, pattern wraps past 2^32
    corrupt_en = 1'b1;
    exp_q    = '{32'h100, 32'hFFFFFFFE, 32'h104, 32'hFFFFFFFF, 32'h108, 32'h0, 32'h10C, 32'h1};
    exp_rd_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    run(32'h100, 16'd4, 32'hFFFFFFFE, 100, 1'b0, cyc);
    check("corrupt_done_cyc", 32'(cyc), 32'd18);
    check_traffic("corrupt");
    repeat (3) @(negedge clk);
    check("corrupt_err_hold", 32'(error_count), 32'd1);
    check("corrupt_first_hold", first_err_addr, 32'h108);
    corrupt_en = 1'b0;

    // responder silent: request times out
    resp_en = 1'b0;
    run(32'h100, 16'd4, 32'h10, 100, 1'b0, cyc);
    check("tmo_done_cyc", 32'(cyc), 32'd10);
    check("tmo_valid_cycles", 32'(valid_cycles), 32'(TIMEOUT));
    check("tmo_flag", 32'(timeout), 32'd1);
    check("tmo_err_cleared", 32'(error_count), 32'd0);
    check("tmo_first_cleared", first_err_addr, 32'd0);
    repeat (20) @(negedge clk);
    check("tmo_no_more_req", 32'(valid_cycles), 32'(TIMEOUT));
    check("tmo_flag_hold", 32'(timeout), 32'd1);
    resp_en = 1'b1;

    // zero-length run
    run(32'h100, 16'd0, 32'h10, 20, 1'b0, cyc);
    check("zero_done_cyc", 32'(cyc), 32'd2);
    check("zero_valid_cycles", 32'(valid_cycles), 32'd0);
    check("zero_timeout_cleared", 32'(timeout), 32'd0);

    // reset during the third write
    wr_addr_q.delete();
    base_addr  = 32'h100;
    word_count = 16'd4;
    seed       = 32'h10;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_valid", 32'(mem_valid), 32'd1);
    check("rst_mid_addr", mem_addr, 32'h108);
    resetn = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    resetn = 1'b1;
    valid_cycles = 0;
    repeat (5) @(negedge clk);
    check("rst_no_req", 32'(valid_cycles), 32'd0);
    exp_q    = '{32'h100, 32'h10, 32'h104, 32'h11, 32'h108, 32'h12, 32'h10C, 32'h13};
    exp_rd_q = '{32'h100, 32'h104, 32'h108, 32'h10C};
    run(32'h100, 16'd4, 32'h10, 100, 1'b0, cyc);
    check("rerun_done_cyc", 32'(cyc), 32'd18);
    check("rerun_err", 32'(error_count), 32'd0);
    check_traffic("rerun");

    // address wrap with a start pulse while busy
    exp_q    = '{32'hFFFFFFF8, 32'h55, 32'hFFFFFFFC, 32'h56, 32'h0, 32'h57, 32'h4, 32'h58};
    exp_rd_q = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4};
    run(32'hFFFFFFF8, 16'd4, 32'h55, 100, 1'b1, cyc);
    check("wrap_done_cyc", 32'(cyc), 32'd18);
    check("wrap_err", 32'(error_count), 32'd0);
    check_traffic("wrap");
    repeat (5) @(negedge clk);
    check("wrap_idle_after", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
